seq_detector_param: RTL and testbench

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

---
 rtl/seq_detector_param.sv | 98 +++++++++
 tb/tb_seq_detector_param.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parameterised symbol-sequence detector (strict/run modes, loadable pattern)
// Optional saturating hit counter on match_cnt when SEQDET_CNT_EN is defined.
module seq_detector_param #(
    parameter int SYM_W   = 2,
    parameter int PAT_LEN = 3,
    parameter logic [SYM_W*PAT_LEN-1:0] RESET_PAT = 6'b11_10_01
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [SYM_W-1:0]         num,
    input  logic                     mode,
    input  logic                     pat_load,
    input  logic [SYM_W*PAT_LEN-1:0] pat_data,
    output logic                     ans,
    output logic                     hit
`ifdef SEQDET_CNT_EN
    ,
    output logic [15:0]              match_cnt
`endif
);

    localparam int             KW     = $clog2(PAT_LEN + 1);
    localparam logic [KW-1:0]  K_FULL = KW'(PAT_LEN);
    localparam logic [KW-1:0]  K_ONE  = KW'(1);

    logic [SYM_W*PAT_LEN-1:0] r_pat;
    logic [KW-1:0]            r_k;
    logic                     r_hit;

    logic [SYM_W-1:0]         w_cur;
    logic [SYM_W-1:0]         w_prev;
    logic [KW-1:0]            w_restart;
    logic [KW-1:0]            w_k_next;

    // w_cur = pat[k] (symbol that advances), w_prev = pat[k-1] (symbol that may repeat)
    always_comb begin
        w_cur  = '0;
        w_prev = '0;
        for (int i = 0; i < PAT_LEN; i++) begin
            if (r_k == KW'(i))
                w_cur = r_pat[i*SYM_W +: SYM_W];
            if (r_k == KW'(i + 1))
                w_prev = r_pat[i*SYM_W +: SYM_W];
        end
    end

    assign w_restart = (num == r_pat[SYM_W-1:0]) ? K_ONE : '0;

    always_comb begin
        w_k_next = w_restart;
        if (r_k == K_FULL) begin
            if (mode && (num == w_prev))
                w_k_next = K_FULL;
        end else if (num == w_cur) begin
            w_k_next = r_k + K_ONE;
        end else if (mode && (r_k != '0) && (num == w_prev)) begin
            w_k_next = r_k;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pat <= RESET_PAT;
            r_k   <= '0;
            r_hit <= 1'b0;
        end else if (pat_load) begin
            r_pat <= pat_data;
            r_k   <= '0;
            r_hit <= 1'b0;
        end else if (in_valid) begin
            r_k   <= w_k_next;
            r_hit <= (w_k_next == K_FULL) && (r_k != K_FULL);
        end else begin
            r_hit <= 1'b0;
        end
    end

    assign ans = (r_k == K_FULL);
    assign hit = r_hit;

`ifdef SEQDET_CNT_EN
    logic [15:0] r_match_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_match_cnt <= '0;
        end else if (pat_load) begin
            r_match_cnt <= '0;
        end else if (r_hit && (r_match_cnt != 16'hFFFF)) begin
            r_match_cnt <= r_match_cnt + 16'd1;
        end
    end

    assign match_cnt = r_match_cnt;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - table-driven bench for seq_detector_param (counter checks when SEQDET_CNT_EN)
module tb_seq_detector_param;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [1:0] num;
    logic       mode;
    logic       pat_load;
    logic [5:0] pat_data;
    logic       ans;
    logic       hit;
`ifdef SEQDET_CNT_EN
    logic [15:0] match_cnt;
`endif

    int checks;
    int errors;

    seq_detector_param dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .num      (num),
        .mode     (mode),
        .pat_load (pat_load),
        .pat_data (pat_data),
        .ans      (ans),
        .hit      (hit)
`ifdef SEQDET_CNT_EN
        ,
        .match_cnt(match_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        m;
        logic [1:0]  n;
        logic        pl;
        logic [5:0]  pd;
        logic        e_ans;
        logic        e_hit;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[27];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic m, input logic [1:0] n,
                        input logic pl, input logic [5:0] pd);
        @(negedge clk);
        in_valid = v;
        mode     = m;
        num      = n;
        pat_load = pl;
        pat_data = pd;
        @(posedge clk);
        #1;
    endtask

    task automatic strict_sym(input logic [1:0] n);
        step(1'b1, 1'b0, n, 1'b0, 6'd0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        mode     = 1'b0;
        num      = 2'd0;
        pat_load = 1'b0;
        pat_data = 6'd0;

        // v, mode, num, pat_load, pat_data, ans, hit, cnt after the edge
        vecs[0]  = '{1, 1, 1, 0, 6'd0, 0, 0, 0};
        vecs[1]  = '{1, 1, 1, 0, 6'd0, 0, 0, 0};
        vecs[2]  = '{1, 1, 2, 0, 6'd0, 0, 0, 0};
        vecs[3]  = '{1, 1, 2, 0, 6'd0, 0, 0, 0};
        vecs[4]  = '{1, 1, 3, 0, 6'd0, 1, 1, 0};
        vecs[5]  = '{1, 1, 3, 0, 6'd0, 1, 0, 1};
        vecs[6]  = '{1, 1, 1, 0, 6'd0, 0, 0, 1};
        vecs[7]  = '{1, 0, 0, 0, 6'd0, 0, 0, 1};
        vecs[8]  = '{1, 0, 1, 0, 6'd0, 0, 0, 1};
        vecs[9]  = '{1, 0, 2, 0, 6'd0, 0, 0, 1};
        vecs[10] = '{1, 0, 3, 0, 6'd0, 1, 1, 1};
        vecs[11] = '{1, 0, 3, 0, 6'd0, 0, 0, 2};
        vecs[12] = '{1, 0, 1, 0, 6'd0, 0, 0, 2};
        vecs[13] = '{1, 0, 1, 0, 6'd0, 0, 0, 2};
        vecs[14] = '{1, 0, 2, 0, 6'd0, 0, 0, 2};
        vecs[15] = '{1, 0, 3, 0, 6'd0, 1, 1, 2};
        vecs[16] = '{1, 0, 1, 0, 6'd0, 0, 0, 3};
        vecs[17] = '{1, 0, 2, 0, 6'd0, 0, 0, 3};
        vecs[18] = '{1, 0, 3, 0, 6'd0, 1, 1, 3};
        vecs[19] = '{0, 0, 1, 0, 6'd0, 1, 0, 4};
        vecs[20] = '{1, 1, 3, 0, 6'd0, 1, 0, 4};
        vecs[21] = '{1, 0, 1, 0, 6'd0, 0, 0, 4};
        vecs[22] = '{1, 0, 2, 0, 6'd0, 0, 0, 4};
        vecs[23] = '{1, 0, 3, 1, 6'b01_01_10, 0, 0, 0};
        vecs[24] = '{1, 0, 2, 0, 6'd0, 0, 0, 0};
        vecs[25] = '{1, 0, 1, 0, 6'd0, 0, 0, 0};
        vecs[26] = '{1, 0, 1, 0, 6'd0, 1, 1, 0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ans", 32'(ans), 32'd0);
        chk("reset_hit", 32'(hit), 32'd0);
`ifdef SEQDET_CNT_EN
        chk("reset_cnt", 32'(match_cnt), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 27; i++) begin
            step(vecs[i].v, vecs[i].m, vecs[i].n, vecs[i].pl, vecs[i].pd);
            chk($sformatf("vec%0d_ans", i), 32'(ans), 32'(vecs[i].e_ans));
            chk($sformatf("vec%0d_hit", i), 32'(hit), 32'(vecs[i].e_hit));
`ifdef SEQDET_CNT_EN
            chk($sformatf("vec%0d_cnt", i), 32'(match_cnt), 32'(vecs[i].e_cnt));
`endif
        end

        // Asynchronous reset between edges while matched and hit is high
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("async_rst_ans", 32'(ans), 32'd0);
        chk("async_rst_hit", 32'(hit), 32'd0);
        chk("async_rst_k", 32'(dut.r_k), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Default pattern 1,2,3 must be back: 2 no longer starts a match
        strict_sym(2'd2);
        chk("post_rst_2_ans", 32'(ans), 32'd0);
        strict_sym(2'd1);
        strict_sym(2'd2);
        chk("post_rst_12_ans", 32'(ans), 32'd0);
        strict_sym(2'd3);
        chk("post_rst_123_ans", 32'(ans), 32'd1);
        chk("post_rst_123_hit", 32'(hit), 32'd1);

        // Reset mid-sequence at k=2 discards progress
        strict_sym(2'd1);
        strict_sym(2'd2);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_k", 32'(dut.r_k), 32'd0);
        reset = 1'b0;
        strict_sym(2'd3);
        chk("mid_rst_3_ans", 32'(ans), 32'd0);
        chk("mid_rst_3_hit", 32'(hit), 32'd0);

`ifdef SEQDET_CNT_EN
        @(negedge clk);
        force dut.r_match_cnt = 16'hFFFE;
        #1;
        release dut.r_match_cnt;
        for (int j = 0; j < 2; j++) begin
            strict_sym(2'd1);
            strict_sym(2'd2);
            strict_sym(2'd3);
        end
        step(1'b0, 1'b0, 2'd0, 1'b0, 6'd0);
        chk("cnt_saturate", 32'(match_cnt), 32'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
